tdm_demux2: RTL
===============

# tdm_demux2

Two-channel time-division demultiplexer: the receive end of the 2:1 select-line multiplexer path. It accepts one serial bit stream in which channel A and channel B bits alternate every clock, and rebuilds one WIDTH-bit word per channel. The rebuilt pair is presented on a valid/ready output interface, with framing-error and overrun reporting. It sits after the select-driven mux on the link and feeds downstream word-level logic.

## Interface
- WIDTH, 8: bits per channel word; legal values are 2 to 32.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous reset, active-high.
- din  in  1  serial TDM data bit.
- sync  in  1  frame-start marker, high on the first bit of a frame.
- out_ready  in  1  consumer accepts the word pair.
- a_out  out  WIDTH  reconstructed channel-A word.
- b_out  out  WIDTH  reconstructed channel-B word.
- out_valid  out  1  a_out/b_out hold an unconsumed pair.
- frame_err  out  1  one-cycle pulse: sync arrived mid-frame.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.

## Operation
- Frame layout: 2*WIDTH consecutive bits, starting with slot A.
  - Interleave order is A[MSB], B[MSB], A[MSB-1], B[MSB-1], ..., A[0], B[0].
  - Slot = cnt[0] (0 = A, 1 = B); bit index = WIDTH-1-(cnt>>1).
- State IDLE:
  - din is ignored while sync=0.
  - sync=1: that cycle's din is frame bit 0 (A MSB), cnt<=1, go to RECV.
- State RECV:
  - Each cycle, din shifts into a_sh (A slot) or b_sh (B slot), MSB first; cnt increments.
- Frame completion: at cnt==2*WIDTH-1 (the B LSB cycle), the frame completes and the state returns to IDLE.
  - If the output is free (out_valid=0, or out_valid=1 with out_ready=1): a_out<=a_sh, b_out<={b_sh[WIDTH-2:0],din}, out_valid<=1.
  - Otherwise: overrun pulses next cycle, the frame is dropped, and outputs are unchanged.
- Back-to-back frames: sync may be high in the cycle right after completion. IDLE accepts it as bit 0, so there is no gap.
- Mid-frame sync: sync=1 in RECV with cnt!=0 causes:
  - frame_err pulses next cycle;
  - the partial frame is discarded;
  - the current din is taken as bit 0 of a new frame, cnt<=1, and the state stays RECV.
  - A sync coinciding with the completing cycle (cnt==2*WIDTH-1) is also a frame error; the completing frame is discarded and not loaded.
- Output handshake: a transfer occurs when out_valid && out_ready.
  - out_valid clears on transfer unless a new frame loads in the same cycle, in which case it stays 1 with new data.
  - a_out and b_out are stable while out_valid=1 and out_ready=0.

## Timing
- Reset (asynchronous assert): state=IDLE, cnt=0, a_sh=b_sh=0, a_out=0, b_out=0, out_valid=0, frame_err=0, overrun=0.
- Latency: out_valid rises on the clock edge that samples the B LSB, so it is visible the cycle after the last bit is presented.
- Throughput: one word pair every 2*WIDTH cycles, sustained with sync on every frame start and out_ready=1.
- frame_err and overrun are registered single-cycle pulses, never held.
- Reset asserted mid-frame: everything returns to reset values immediately and the partial frame is lost. The first frame after deassert needs a new sync.

## Test plan
- Basic frame: WIDTH=8, A=0xA5, B=0x3C interleaved MSB-first with sync on bit 0, out_ready=1.
  - Expect out_valid=1 for 1 cycle, starting 16 cycles after sync, with a_out=0xA5, b_out=0x3C.
- Back-to-back: three frames (0x01/0xFE, 0x80/0x7F, 0xFF/0x00) with no gaps.
  - Expect three valid pulses 16 cycles apart, with correct data and no frame_err.
- Backpressure/overrun: out_ready=0, send 0x11/0x22, then 0x33/0x44.
  - Expect out_valid to hold 0x11/0x22 and overrun to pulse once after frame 2.
  - Then raise out_ready: the transfer occurs and out_valid drops.
- Same-cycle accept and load: out_valid=1 and out_ready=1 on the completion cycle of the next frame.
  - Expect out_valid to stay 1, with new data loaded and no overrun.
- Mid-frame sync: sync at bit 5 of a frame, then a full frame 0x5A/0xC3.
  - Expect one frame_err pulse and a_out=0x5A, b_out=0xC3.
- Reset mid-frame: assert rst at bit 9, release it, then send 0x96/0x69.
  - Expect all outputs 0 during reset, then a clean 0x96/0x69 with no err or overrun.

Source files
------------

// File: rtl/tdm_demux2.sv
// Two-channel TDM demux: rebuilds interleaved A/B serial bits into a WIDTH-bit word pair.
// out_valid rises on the edge sampling the B LSB; a held pair that is not consumed causes later frames to be dropped (overrun).
module tdm_demux2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             sync,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             out_valid,
    output logic             frame_err,
    output logic             overrun
);
    localparam int CW = $clog2(2 * WIDTH);
    localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             out_free;

    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            a_out     <= '0;
            b_out     <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync) begin
                        a_sh  <= {{(WIDTH-1){1'b0}}, din};
                        b_sh  <= '0;
                        cnt   <= CW'(1);
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (sync) begin
                        // Resynchronise: this bit starts a fresh frame, partial one is lost.
                        frame_err <= 1'b1;
                        a_sh      <= {{(WIDTH-1){1'b0}}, din};
                        b_sh      <= '0;
                        cnt       <= CW'(1);
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        if (out_free) begin
                            a_out     <= a_sh;
                            b_out     <= {b_sh[WIDTH-2:0], din};
                            out_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        if (cnt[0])
                            b_sh <= {b_sh[WIDTH-2:0], din};
                        else
                            a_sh <= {a_sh[WIDTH-2:0], din};
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
